// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by the load/store controller and its byte-lane helper.
//   - access size encodings as they appear on req_size
//   - FSM state encoding of lsu_mem_ctrl
//   - lane masks and the big-endian lane shift helper
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  localparam logic [31:0] LANE_MASK_B = 32'h0000_00FF;
  localparam logic [31:0] LANE_MASK_H = 32'h0000_FFFF;

  // Right-shift that brings the addressed lane down to bit 0. Big-endian:
  // the lowest offset sits in the most significant lane, so a byte at
  // offset k lives at bit (3-k)*8 and a half at offset 0 lives at bit 16.
  function automatic logic [4:0] lane_shift(input logic [1:0] size,
                                            input logic [1:0] off);
    if (size == SZ_HALF) lane_shift = off[1] ? 5'd0 : 5'd16;
    else                 lane_shift = {~off, 3'b000};
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: combinational lane extract / merge for sub-word accesses.
// Ports:
//   i_offset  byte offset within the word (addr[1:0])
//   i_size    access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   i_signed  sign-extend loaded byte/half when 1
//   i_word    word currently held in memory
//   i_wdata   right-justified store data
//   o_load    extracted and extended load value (whole word for word size)
//   o_store   i_word with the addressed lane replaced by i_wdata (i_wdata for word size)
module lsu_byte_lane
  import mem_pkg::*;
(
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [4:0]  w_sh;
  logic [31:0] w_mask;
  logic [31:0] w_lane;
  logic signed [31:0] w_sext_b;
  logic signed [31:0] w_sext_h;

  always_comb begin
    w_sh     = lane_shift(i_size, i_offset);
    w_mask   = (i_size == SZ_HALF) ? LANE_MASK_H : LANE_MASK_B;
    w_lane   = (i_word >> w_sh) & w_mask;
    w_sext_b = 32'(signed'(w_lane[7:0]));
    w_sext_h = 32'(signed'(w_lane[15:0]));
    o_load   = w_lane;
    o_store  = (i_word & ~(w_mask << w_sh)) | ((i_wdata & w_mask) << w_sh);
    case (i_size)
      SZ_BYTE: if (i_signed) o_load = w_sext_b;
      SZ_HALF: if (i_signed) o_load = w_sext_h;
      default: begin
        // word access: no lane selection, signedness is irrelevant
        o_load  = i_word;
        o_store = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store controller driving a word-only data memory.
// Sub-word stores are read-modify-write; loads are sign/zero extended.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_write, req_size, req_signed, req_addr, req_wdata   request fields
//   resp_valid, resp_rdata, resp_err                      one-cycle response
//   MemRead, MemWrite, Address, Write_data, Read_data      memory port
module lsu_mem_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  input  logic [31:0] Read_data
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  lsu_state_t  r_state, w_next;
  logic        w_accept;
  logic        w_err;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_word;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] r_addr;
  logic [31:0] r_write_data;
  logic [31:0] w_lane_word;
  logic [31:0] w_load;
  logic [31:0] w_store;

  // request checks, evaluated on the live request fields at acceptance
  always_comb begin
    w_err = 1'b0;
    if (req_size == SZ_ILL)                              w_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])              w_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)   w_err = 1'b1;
    if ({1'b0, req_addr} >= ADDR_LIMIT)                  w_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (w_err)                                  w_next = RESP;
          else if (!req_write || req_size != SZ_WORD) w_next = RD;
          else                                        w_next = WR;
        end
      end
      RD:      w_next = r_write ? WR : RESP;
      WR:      w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // During RD the lane logic works on the word arriving from memory (to
  // build the merged store word); afterwards it works on the captured word
  // (to produce the load result in RESP).
  assign w_lane_word = (r_state == RD) ? Read_data : r_word;

  lsu_byte_lane u_lane (
    .i_offset (r_off),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_word   (w_lane_word),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_store  (w_store)
  );

  // acceptance capture / memory-port registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write      <= 1'b0;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_off        <= 2'b00;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      r_word       <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_addr       <= '0;
      r_write_data <= '0;
    end else begin
      // strobes follow the state being entered, so each lasts exactly one state
      r_mem_read  <= (w_next == RD);
      r_mem_write <= (w_next == WR);
      if (w_accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_off    <= req_addr[1:0];
        r_wdata  <= req_wdata;
        r_err    <= w_err;
        if (!w_err) r_addr <= {req_addr[31:2], 2'b00};
        if (!w_err && req_write && req_size == SZ_WORD) r_write_data <= req_wdata;
      end
      if (r_state == RD) begin
        r_word <= Read_data;
        if (r_write) r_write_data <= w_store;
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_err   = resp_valid & r_err;
  assign resp_rdata = (resp_valid && !r_err && !r_write) ? w_load : 32'h0;
  assign MemRead    = r_mem_read;
  assign MemWrite   = r_mem_write;
  assign Address    = r_addr;
  assign Write_data = r_write_data;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;

  lsu_mem_ctrl #(.MEM_WORDS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .Write_data(Write_data), .Read_data(Read_data)
  );

  always #5 clk = ~clk;

  // data-memory responder
  logic [31:0] mem [0:31];
  initial for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  assign Read_data = MemRead ? mem[Address[6:2]] : 32'h0;
  always @(posedge clk) if (MemWrite) mem[Address[6:2]] <= Write_data;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          nrd;
    int          nwr;
    logic [31:0] wdata;
    logic [31:0] addr;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];

  // monitor: strobe bookkeeping and response scoreboard
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] seen_wd = '0;
  logic [31:0] seen_addr = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (MemRead && MemWrite) check("strobes_exclusive", 32'd1, 32'd0);
      if (MemRead)  begin rd_cnt++; seen_addr = Address; end
      if (MemWrite) begin wr_cnt++; seen_addr = Address; seen_wd = Write_data; end
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check({e.name, "_rdata"}, resp_rdata, e.rdata);
          check({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
          check({e.name, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
          check({e.name, "_nread"}, 32'(rd_cnt), 32'(e.nrd));
          check({e.name, "_nwrite"}, 32'(wr_cnt), 32'(e.nwr));
          check({e.name, "_ready_in_resp"}, {31'd0, req_ready}, 32'd0);
          if (e.nwr > 0) check({e.name, "_wdata"}, seen_wd, e.wdata);
          if (e.nrd + e.nwr > 0) check({e.name, "_addr"}, seen_addr, e.addr);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic issue(input string nm, input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd, input int e_nrd,
                       input int e_nwr, input logic [31:0] e_wd, input int e_lat,
                       input bit hold);
    exp_t e;
    int guard;
    guard = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check({nm, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      e.name = nm; e.err = e_err; e.rdata = e_rd; e.nrd = e_nrd; e.nwr = e_nwr;
      e.wdata = e_wd; e.addr = {a[31:2], 2'b00}; e.lat = e_lat; e.acc = cyc + 1;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      check({nm, "_ready_after_accept"}, {31'd0, req_ready}, 32'd0);
      if (!hold) req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sbq.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #2;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_memread", {31'd0, MemRead}, 32'd0);
    check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check("rst_address", Address, 32'd0);
    check("rst_write_data", Write_data, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // word store / load round trip
    issue("sw10", 1, 2'b10, 0, 32'h10, 32'h12345678, 0, 32'h0, 0, 1, 32'h12345678, 2, 0);
    issue("lw10", 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h12345678, 1, 0, 32'h0, 2, 0);

    // read-modify-write sub-word stores
    issue("sw20", 1, 2'b10, 0, 32'h20, 32'h11223344, 0, 32'h0, 0, 1, 32'h11223344, 2, 0);
    issue("sb21", 1, 2'b00, 0, 32'h21, 32'hFFFF_FFAB, 0, 32'h0, 1, 1, 32'h11AB3344, 3, 0);
    issue("sh22", 1, 2'b01, 0, 32'h22, 32'h1234_BEEF, 0, 32'h0, 1, 1, 32'h11ABBEEF, 3, 0);
    issue("lw20", 0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h11ABBEEF, 1, 0, 32'h0, 2, 0);

    // extension of sub-word loads
    issue("sw30", 1, 2'b10, 0, 32'h30, 32'h80FF7F01, 0, 32'h0, 0, 1, 32'h80FF7F01, 2, 0);
    issue("lb30", 0, 2'b00, 1, 32'h30, 32'h0, 0, 32'hFFFFFF80, 1, 0, 32'h0, 2, 0);
    issue("lbu31", 0, 2'b00, 0, 32'h31, 32'h0, 0, 32'h000000FF, 1, 0, 32'h0, 2, 0);
    issue("lh32", 0, 2'b01, 1, 32'h32, 32'h0, 0, 32'h00007F01, 1, 0, 32'h0, 2, 0);
    issue("lhu30", 0, 2'b01, 0, 32'h30, 32'h0, 0, 32'h000080FF, 1, 0, 32'h0, 2, 0);
    issue("lh30", 0, 2'b01, 1, 32'h30, 32'h0, 0, 32'hFFFF80FF, 1, 0, 32'h0, 2, 0);
    issue("lb33", 0, 2'b00, 1, 32'h33, 32'h0, 0, 32'h00000001, 1, 0, 32'h0, 2, 0);
    issue("lbu32", 0, 2'b00, 0, 32'h32, 32'h0, 0, 32'h0000007F, 1, 0, 32'h0, 2, 0);
    issue("lw30_sgn", 0, 2'b10, 1, 32'h30, 32'h0, 0, 32'h80FF7F01, 1, 0, 32'h0, 2, 0);

    // error cases: no strobe, response one cycle after acceptance
    issue("lh05_mis", 0, 2'b01, 1, 32'h05, 32'h0, 1, 32'h0, 0, 0, 32'h0, 1, 0);
    issue("lw0e_mis", 0, 2'b10, 0, 32'h0E, 32'h0, 1, 32'h0, 0, 0, 32'h0, 1, 0);
    issue("sz3_ill", 0, 2'b11, 0, 32'h00, 32'h0, 1, 32'h0, 0, 0, 32'h0, 1, 0);
    issue("lb80_oor", 0, 2'b00, 0, 32'h80, 32'h0, 1, 32'h0, 0, 0, 32'h0, 1, 0);
    issue("sb80_oor", 1, 2'b00, 0, 32'h80, 32'h55, 1, 32'h0, 0, 0, 32'h0, 1, 0);
    issue("sw7c_last", 1, 2'b10, 0, 32'h7C, 32'hCAFEF00D, 0, 32'h0, 0, 1, 32'hCAFEF00D, 2, 0);
    issue("lw7c_last", 0, 2'b10, 0, 32'h7C, 32'h0, 0, 32'hCAFEF00D, 1, 0, 32'h0, 2, 0);

    // req_valid held high across three queued requests
    issue("q_lw10", 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h12345678, 1, 0, 32'h0, 2, 1);
    issue("q_sb13", 1, 2'b00, 0, 32'h13, 32'h5A, 0, 32'h0, 1, 1, 32'h1234565A, 3, 1);
    issue("q_lw10b", 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h1234565A, 1, 0, 32'h0, 2, 0);
    drain();

    // reset in the middle of a word store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h04; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rstwr_memwrite_before", {31'd0, MemWrite}, 32'd1);
    check("rstwr_wdata_before", Write_data, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check("rstwr_memwrite_dropped", {31'd0, MemWrite}, 32'd0);
    check("rstwr_ready", {31'd0, req_ready}, 32'd1);
    check("rstwr_no_resp", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstwr_mem04", mem[1], 32'h0);
    issue("lw04_after_rst", 0, 2'b10, 0, 32'h04, 32'h0, 0, 32'h0, 1, 0, 32'h0, 2, 0);
    issue("lw10_after_rst", 0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h1234565A, 1, 0, 32'h0, 2, 0);
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
